// File: rtl/bsg_manycore_link_sdr_mux.sv
// bsg_manycore_link_sdr_mux
//
// Credit-based multiplexer that carries num_channels_p ready/valid streams
// over one shared SDR phit link on a single clock.
//   Outbound: round-robin arbitration over channels that are valid and
//     hold credit. The grant is combinational (core_yumi_o) and the phit
//     {chan_id, payload} is registered onto link_data_o/link_v_o.
//   Inbound: link phits are steered into per-channel FIFOs by chan_id.
//     Every 2**lg_credit_to_token_decimation_p dequeues on a channel
//     return one token pulse on link_token_o.
//
// Ports
//   core_clk_i, core_reset_i   clock, synchronous active-high reset
//   core_data_i/core_v_i       outbound payload/valid per channel
//   core_yumi_o                outbound accept (one-hot or zero)
//   core_data_o/core_v_o       inbound FIFO head/non-empty per channel
//   core_yumi_i                inbound dequeue per channel
//   link_data_o/link_v_o       outbound phit
//   link_token_i               credit tokens from the far side
//   link_data_i/link_v_i       inbound phit
//   link_token_o               token pulses to the far side
//   error_o                    sticky protocol error
//
// Optional feature: define BSG_LINK_SDR_MUX_CREDIT_CHECK_EN to build the
// protocol checker (out-of-range chan_id, enqueue into full FIFO, credit
// overflow) with credit saturation. Without it error_o is 0 and the
// credit counters wrap.

module bsg_manycore_link_sdr_mux #(
  parameter int width_p                         = 16,
  parameter int num_channels_p                  = 2,
  parameter int lg_fifo_depth_p                 = 3,
  parameter int lg_credit_to_token_decimation_p = 1,
  localparam int chan_id_width_lp = (num_channels_p > 1) ? $clog2(num_channels_p) : 1,
  localparam int link_width_lp    = chan_id_width_lp + width_p
) (
  input  logic                                core_clk_i,
  input  logic                                core_reset_i,

  input  logic [num_channels_p*width_p-1:0]   core_data_i,
  input  logic [num_channels_p-1:0]           core_v_i,
  output logic [num_channels_p-1:0]           core_yumi_o,

  output logic [num_channels_p*width_p-1:0]   core_data_o,
  output logic [num_channels_p-1:0]           core_v_o,
  input  logic [num_channels_p-1:0]           core_yumi_i,

  output logic [link_width_lp-1:0]            link_data_o,
  output logic                                link_v_o,
  input  logic [num_channels_p-1:0]           link_token_i,

  input  logic [link_width_lp-1:0]            link_data_i,
  input  logic                                link_v_i,
  output logic [num_channels_p-1:0]           link_token_o,

  output logic                                error_o
);

  localparam int fifo_depth_lp   = 1 << lg_fifo_depth_p;
  localparam int credit_width_lp = lg_fifo_depth_p + 1;
  localparam int dec_width_lp    = (lg_credit_to_token_decimation_p > 0)
                                   ? lg_credit_to_token_decimation_p : 1;
  localparam logic [dec_width_lp-1:0] dec_max_lp =
    dec_width_lp'((1 << lg_credit_to_token_decimation_p) - 1);
  localparam logic [credit_width_lp-1:0] credit_init_lp = credit_width_lp'(fifo_depth_lp);

`ifdef BSG_LINK_SDR_MUX_CREDIT_CHECK_EN
  // One spare bit so an overflow past the maximum can be seen and clamped.
  localparam int sum_width_lp = credit_width_lp + 1;
  localparam logic [sum_width_lp-1:0] credit_max_lp = sum_width_lp'(fifo_depth_lp);
`else
  localparam int sum_width_lp = credit_width_lp;
`endif
  localparam logic [sum_width_lp-1:0] token_inc_lp =
    sum_width_lp'(1 << lg_credit_to_token_decimation_p);

  // ---------------------------------------------------------------------
  // Outbound arbitration and credits
  // ---------------------------------------------------------------------
  logic [credit_width_lp-1:0]  credit_r    [num_channels_p];
  logic [credit_width_lp-1:0]  credit_next [num_channels_p];
  logic [sum_width_lp-1:0]     credit_sum  [num_channels_p];
  logic [chan_id_width_lp-1:0] rr_ptr_r;
  logic [num_channels_p-1:0]   eligible;
  logic [num_channels_p-1:0]   grant;
  logic                        grant_v;
  logic [chan_id_width_lp-1:0] grant_id;
  logic [width_p-1:0]          grant_data;
  logic                        link_v_r;
  logic [link_width_lp-1:0]    link_data_r;

  always_comb begin
    eligible = '0;
    for (int unsigned c = 0; c < num_channels_p; c++) begin
      eligible[c] = core_v_i[c] & (credit_r[c] != '0);
    end
  end

  // Scan channels starting at the pointer; the first eligible one wins.
  always_comb begin
    int unsigned cand;
    logic [chan_id_width_lp-1:0] cand_id;
    grant    = '0;
    grant_v  = 1'b0;
    grant_id = '0;
    cand     = 0;
    cand_id  = '0;
    for (int unsigned i = 0; i < num_channels_p; i++) begin
      cand    = (32'(rr_ptr_r) + i) % 32'(num_channels_p);
      cand_id = chan_id_width_lp'(cand);
      if (!grant_v && eligible[cand_id]) begin
        grant[cand_id] = 1'b1;
        grant_v        = 1'b1;
        grant_id       = cand_id;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int unsigned c = 0; c < num_channels_p; c++) begin
      if (grant[c]) grant_data = core_data_i[c*width_p +: width_p];
    end
  end

  assign core_yumi_o = grant;

  // Token and grant in the same cycle fold into a single net update.
  always_comb begin
    for (int unsigned c = 0; c < num_channels_p; c++) begin
      credit_sum[c] = sum_width_lp'(credit_r[c])
                    + (link_token_i[c] ? token_inc_lp : '0)
                    - sum_width_lp'(grant[c]);
    end
  end

`ifdef BSG_LINK_SDR_MUX_CREDIT_CHECK_EN
  logic [num_channels_p-1:0] credit_ovf;
  always_comb begin
    credit_ovf = '0;
    for (int unsigned c = 0; c < num_channels_p; c++) begin
      credit_ovf[c]  = credit_sum[c] > credit_max_lp;
      credit_next[c] = credit_ovf[c] ? credit_init_lp
                                     : credit_sum[c][credit_width_lp-1:0];
    end
  end
`else
  always_comb begin
    for (int unsigned c = 0; c < num_channels_p; c++) begin
      credit_next[c] = credit_sum[c];
    end
  end
`endif

  assign link_v_o    = link_v_r;
  assign link_data_o = link_data_r;

  // ---------------------------------------------------------------------
  // Inbound demux, FIFOs and token return
  // ---------------------------------------------------------------------
  logic [chan_id_width_lp-1:0] in_id;
  logic [width_p-1:0]          in_payload;
  logic                        in_range;
  logic [num_channels_p-1:0]   in_sel;

  assign in_id      = link_data_i[link_width_lp-1 -: chan_id_width_lp];
  assign in_payload = link_data_i[width_p-1:0];

  if ((1 << chan_id_width_lp) == num_channels_p) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    assign in_range = 32'(in_id) < 32'(num_channels_p);
  end

  logic [width_p-1:0]          fifo_mem_r [num_channels_p][fifo_depth_lp];
  logic [lg_fifo_depth_p:0]    wptr_r     [num_channels_p];
  logic [lg_fifo_depth_p:0]    rptr_r     [num_channels_p];
  logic [num_channels_p-1:0]   fifo_empty, fifo_full, enq, deq;
  logic [dec_width_lp-1:0]     dec_cnt_r  [num_channels_p];
  logic [num_channels_p-1:0]   link_token_r;

  always_comb begin
    in_sel     = '0;
    fifo_empty = '0;
    fifo_full  = '0;
    enq        = '0;
    deq        = '0;
    for (int unsigned c = 0; c < num_channels_p; c++) begin
      in_sel[c]     = link_v_i & in_range & (in_id == chan_id_width_lp'(c));
      fifo_empty[c] = wptr_r[c] == rptr_r[c];
      fifo_full[c]  = (wptr_r[c][lg_fifo_depth_p] != rptr_r[c][lg_fifo_depth_p])
                    && (wptr_r[c][lg_fifo_depth_p-1:0] == rptr_r[c][lg_fifo_depth_p-1:0]);
      enq[c]        = in_sel[c] & ~fifo_full[c];
      deq[c]        = core_yumi_i[c] & ~fifo_empty[c];
    end
  end

  always_comb begin
    core_data_o = '0;
    for (int unsigned c = 0; c < num_channels_p; c++) begin
      core_data_o[c*width_p +: width_p] = fifo_mem_r[c][rptr_r[c][lg_fifo_depth_p-1:0]];
    end
  end

  assign core_v_o     = ~fifo_empty;
  assign link_token_o = link_token_r;

  always_ff @(posedge core_clk_i) begin
    for (int unsigned c = 0; c < num_channels_p; c++) begin
      if (enq[c]) fifo_mem_r[c][wptr_r[c][lg_fifo_depth_p-1:0]] <= in_payload;
    end
  end

  always_ff @(posedge core_clk_i) begin
    if (core_reset_i) begin
      rr_ptr_r     <= '0;
      link_v_r     <= 1'b0;
      link_data_r  <= '0;
      link_token_r <= '0;
      for (int unsigned c = 0; c < num_channels_p; c++) begin
        credit_r[c]  <= credit_init_lp;
        wptr_r[c]    <= '0;
        rptr_r[c]    <= '0;
        dec_cnt_r[c] <= '0;
      end
    end else begin
      link_v_r <= grant_v;
      if (grant_v) begin
        link_data_r <= {grant_id, grant_data};
        rr_ptr_r    <= (grant_id == chan_id_width_lp'(num_channels_p - 1))
                       ? '0 : grant_id + 1'b1;
      end
      for (int unsigned c = 0; c < num_channels_p; c++) begin
        credit_r[c]     <= credit_next[c];
        link_token_r[c] <= deq[c] & (dec_cnt_r[c] == dec_max_lp);
        if (enq[c]) wptr_r[c] <= wptr_r[c] + 1'b1;
        if (deq[c]) begin
          rptr_r[c]    <= rptr_r[c] + 1'b1;
          dec_cnt_r[c] <= (dec_cnt_r[c] == dec_max_lp) ? '0 : dec_cnt_r[c] + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Protocol checker
  // ---------------------------------------------------------------------
`ifdef BSG_LINK_SDR_MUX_CREDIT_CHECK_EN
  logic error_r;
  always_ff @(posedge core_clk_i) begin
    if (core_reset_i) begin
      error_r <= 1'b0;
    end else if ((link_v_i & ~in_range) | (|(in_sel & fifo_full)) | (|credit_ovf)) begin
      error_r <= 1'b1;
    end
  end
  assign error_o = error_r;
`else
  assign error_o = 1'b0;
`endif

endmodule
